rv32i_dmem: RTL and testbench

Data-memory responder for the RV32I core: the memory side of the core's load/store port. It accepts one load or store request at a time through a valid/ready handshake and applies RV32I byte/halfword/word lane rules. Loads are returned sign- or zero-extended per func3, and completion is signalled with a held response. It sits between the core's load/store stage and on-chip word-organised SRAM, which it owns internally.

---
 rtl/rv32i_mem_pkg.sv | 25 ++
 rtl/rv32i_load_align.sv | 28 ++
 rtl/rv32i_dmem.sv | 146 ++++++++++++++
 tb/tb_rv32i_dmem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - RV32I load/store func3 encodings, dmem FSM states, byte-enable helper
package rv32i_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, READ, RESP} dmem_state_t;

  // Byte lanes touched by a store; offset must already be naturally aligned.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      SB:      byte_en = 4'b0001 << off;
      SH:      byte_en = off[1] ? 4'b1100 : 4'b0011;
      SW:      byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// rtl/rv32i_load_align.sv - selects and sign/zero-extends load data from a 32-bit word
module rv32i_load_align
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    case (i_func3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LW:      o_data = i_word;
      LBU:     o_data = {24'h0, w_byte};
      LHU:     o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem.sv
// rtl/rv32i_dmem.sv - RV32I data-memory responder with internal word SRAM and lane rules
// Define RV32I_DMEM_MISALIGN_ERR_EN to fault misaligned halfword/word accesses instead of aligning them.
module rv32i_dmem
  import rv32i_mem_pkg::*;
#(
  parameter int width       = 32,
  parameter int depth_words = 1024
) (
  input  logic             CLK,
  input  logic             reset_,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_func3,
  input  logic [width-1:0] req_addr,
  input  logic [width-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(depth_words);
  localparam logic [width-1:0] BYTE_LIMIT = width'(depth_words * 4);

  dmem_state_t      r_state;
  logic [31:0]      r_mem [depth_words];
  logic [AW-1:0]    r_idx;
  logic [1:0]       r_off;
  logic [2:0]       r_func3;
  logic             r_legal;
  logic [width-1:0] r_rdata;
  logic             r_err;
  logic             r_valid;

  logic          w_acc, w_f3_ok, w_mis, w_legal, w_wr;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes, w_load;

  assign req_ready = reset_ && (r_state == IDLE);
  assign rsp_valid = r_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_acc   = req_valid && req_ready;
  assign w_idx   = req_addr[AW+1:2];
  assign w_legal = w_f3_ok && !w_mis && (req_addr < BYTE_LIMIT);
  assign w_wr    = w_acc && req_we && w_legal;
  assign w_be    = byte_en(req_func3, w_off);

  always_comb begin
    if (req_we) w_f3_ok = req_func3 inside {SB, SH, SW};
    else        w_f3_ok = req_func3 inside {LB, LH, LW, LBU, LHU};
  end

`ifdef RV32I_DMEM_MISALIGN_ERR_EN
  always_comb begin
    w_off = req_addr[1:0];
    w_mis = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    w_mis = 1'b0;
    case (req_func3[1:0])
      2'b01:   w_off = {req_addr[1], 1'b0};
      2'b10:   w_off = 2'b00;
      default: w_off = req_addr[1:0];
    endcase
  end
`endif

  always_comb begin
    case (req_func3)
      SB:      w_wlanes = {4{req_wdata[7:0]}};
      SH:      w_wlanes = {2{req_wdata[15:0]}};
      default: w_wlanes = req_wdata[31:0];
    endcase
  end

  // Array is never reset; writes land on the accept edge.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  rv32i_load_align u_align (
    .i_word  (r_mem[r_idx]),
    .i_off   (r_off),
    .i_func3 (r_func3),
    .o_data  (w_load)
  );

  always_ff @(posedge CLK or negedge reset_) begin
    if (!reset_) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_off   <= 2'b00;
      r_func3 <= 3'b000;
      r_legal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (req_we) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_rdata <= '0;
              r_err   <= !w_legal;
            end else begin
              r_state <= READ;
              r_idx   <= w_idx;
              r_off   <= w_off;
              r_func3 <= req_func3;
              r_legal <= w_legal;
            end
          end
        end
        READ: begin
          r_state <= RESP;
          r_valid <= 1'b1;
          r_rdata <= r_legal ? width'(w_load) : '0;
          r_err   <= !r_legal;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem.sv
// tb/tb_rv32i_dmem.sv - scoreboard bench for rv32i_dmem with directed load/store vectors
module tb_rv32i_dmem;
  import rv32i_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        reset_ = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  rv32i_dmem #(.width(32), .depth_words(1024)) dut (
    .CLK       (CLK),
    .reset_    (reset_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 CLK = ~CLK;

  logic [31:0] q_data[$];
  logic        q_err[$];
  string       q_tag[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_d;
  logic        m_e;
  string       m_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response retires on the edge after valid&ready is seen here.
  always @(negedge CLK) begin
    if (reset_ && rsp_valid && rsp_ready) begin
      if (q_data.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        m_d   = q_data.pop_front();
        m_e   = q_err.pop_front();
        m_tag = q_tag.pop_front();
        chk({m_tag, "_rdata"}, rsp_rdata, m_d);
        chk({m_tag, "_err"}, {31'b0, rsp_err}, {31'b0, m_e});
      end
    end
  end

  task automatic req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_d, input bit exp_e,
                     input string tag, output int lat);
    int k;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    k = 0;
    @(negedge CLK);
    while (!req_ready && k < 20) begin @(negedge CLK); k++; end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL %s_accept: got req_ready=0 expected 1 within 20 cycles", tag);
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    q_data.push_back(exp_d); q_err.push_back(exp_e); q_tag.push_back(tag);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      n_checks++; n_errors++;
      $display("FAIL %s_rsp: got rsp_valid=0 expected 1 within 10 cycles", tag);
      lat = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000 time units");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] w10;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
    @(posedge CLK); #1 reset_ = 1'b1;
    @(negedge CLK);
    chk("idle_req_ready", {31'b0, req_ready}, 32'h1);

    req(1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10", lat);
    chk("sw_latency", 32'(lat), 32'd1);
    req(1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10", lat);
    chk("lw_latency", 32'(lat), 32'd2);
    req(1'b1, SB,  32'h13, 32'h12345680, 32'h0,        1'b0, "sb_13",   lat);
    req(1'b0, LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, "lb_13",   lat);
    req(1'b0, LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, "lbu_13",  lat);
    req(1'b0, LHU, 32'h12, 32'h0,        32'h000080AD, 1'b0, "lhu_12",  lat);
    req(1'b0, LW,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, "lw_10b",  lat);
    req(1'b0, LH,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_10",   lat);
    req(1'b0, LB,  32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, "lb_11",   lat);
    req(1'b0, LHU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, "lhu_10",  lat);

    req(1'b0, LW,     32'h1000, 32'h0,        32'h0, 1'b1, "lw_oor",    lat);
    req(1'b1, 3'b011, 32'h10,   32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_011", lat);
    req(1'b0, LW,     32'h10,   32'h0, 32'h80ADBEEF, 1'b0, "lw_after_bad_st", lat);
    req(1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1, "ld_f3_011", lat);
    req(1'b0, 3'b110, 32'h10,   32'h0,        32'h0, 1'b1, "ld_f3_110", lat);
    req(1'b0, 3'b111, 32'h10,   32'h0,        32'h0, 1'b1, "ld_f3_111", lat);
    req(1'b1, SW,     32'h1000, 32'h11111111, 32'h0, 1'b1, "sw_oor",    lat);
    req(1'b1, SB,     32'hFFF,  32'h0000005A, 32'h0, 1'b0, "sb_last",   lat);
    req(1'b0, LBU,    32'hFFF,  32'h0,  32'h0000005A, 1'b0, "lbu_last", lat);

`ifdef RV32I_DMEM_MISALIGN_ERR_EN
    req(1'b0, LW, 32'h11, 32'h0,        32'h0, 1'b1, "lw_mis", lat);
    req(1'b1, SH, 32'h13, 32'hABCD1234, 32'h0, 1'b1, "sh_mis", lat);
    w10 = 32'h80ADBEEF;
`else
    req(1'b0, LW, 32'h11, 32'h0,        32'h80ADBEEF, 1'b0, "lw_mis", lat);
    req(1'b1, SH, 32'h13, 32'hABCD1234, 32'h0,        1'b0, "sh_mis", lat);
    w10 = 32'h1234BEEF;
`endif
    req(1'b0, LW, 32'h10, 32'h0, w10, 1'b0, "lw_after_mis", lat);

    @(posedge CLK); #1 rsp_ready = 1'b0;
    req(1'b0, LW, 32'h10, 32'h0, w10, 1'b0, "lw_bp", lat);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_func3 = SW; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, w10);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("bp_idle_ready", {31'b0, req_ready}, 32'h1);
    chk("bp_idle_valid", {31'b0, rsp_valid}, 32'h0);
    req(1'b0, LW, 32'h10, 32'h0, w10, 1'b0, "lw_after_bp", lat);

    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = LW; req_addr = 32'h10;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("mid_in_read_ready", {31'b0, req_ready}, 32'h0);
    #1 reset_ = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'h0);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 reset_ = 1'b1;
    @(negedge CLK);
    chk("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
    req(1'b0, LW, 32'h10, 32'h0, w10, 1'b0, "lw_post_rst", lat);
    chk("post_rst_latency", 32'(lat), 32'd2);

    repeat (3) @(negedge CLK);
    chk("sb_queue_empty", 32'(q_data.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
